// File: rtl/cla_slice_sequencer_if.sv
// Request/response handshake bundle for the slice sequencer.
interface cla_slice_sequencer_if #(
  parameter int unsigned W = 20
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         result_cout;

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, result, result_cout
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, result, result_cout
  );
endinterface

// File: rtl/cla_slice_sequencer.sv
// Feeds a wide addition through a 5-bit CLA one slice at a time, LSB slice
// first, chaining the adder's carry-out into the next slice's carry-in.
module cla_slice_sequencer #(
  parameter int unsigned NSLICE    = 4,
  parameter int unsigned ADDER_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_slice_sequencer_if.slave bus,
  output logic [4:0]           a_in,
  output logic [4:0]           b_in,
  output logic                 cin,
  input  logic [4:0]           sum,
  input  logic                 cout,
  output logic                 busy
);
  localparam int unsigned W  = 5 * NSLICE;
  localparam int unsigned KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t          state_q, state_n;
  logic [KW-1:0]   k_q;
  logic [1:0]      cnt_q;
  logic [W-1:0]    a_sh, b_sh;
  logic [W-1:0]    a_nxt, b_nxt;
  logic [W-1:0]    result_q;
  logic            result_cout_q;
  logic [4:0]      a_in_q, b_in_q;
  logic            carry_q;
  logic            in_ready_w;
  logic            slice_end;
  logic            last_slice;

  assign in_ready_w = (state_q == IDLE) && rst_n;
  assign slice_end  = (state_q == ISSUE) && (cnt_q == 2'(ADDER_LAT));
  assign last_slice = (k_q == KW'(NSLICE - 1));

  // Latched operands are shifted down one slice at a time so slice k always
  // sits in the low 5 bits; this avoids variable-width operand selects.
  assign a_nxt = a_sh >> 5;
  assign b_nxt = b_sh >> 5;

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.result_cout = result_cout_q;
  assign a_in            = a_in_q;
  assign b_in            = b_in_q;
  // The carry register doubles as the registered cin output: it holds the
  // incoming carry for the current slice and is cleared outside ISSUE.
  assign cin             = carry_q;
  assign busy            = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid && in_ready_w) state_n = ISSUE;
      ISSUE:   if (slice_end && last_slice)    state_n = DONE;
      DONE:    if (bus.out_ready)              state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, slice issue, result collection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q           <= '0;
      cnt_q         <= '0;
      a_sh          <= '0;
      b_sh          <= '0;
      result_q      <= '0;
      result_cout_q <= 1'b0;
      a_in_q        <= '0;
      b_in_q        <= '0;
      carry_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.op_a;
            b_sh    <= bus.op_b;
            k_q     <= '0;
            cnt_q   <= '0;
            a_in_q  <= bus.op_a[4:0];
            b_in_q  <= bus.op_b[4:0];
            carry_q <= bus.op_cin;
          end
        end
        ISSUE: begin
          if (slice_end) begin
            result_q[int'(k_q) * 5 +: 5] <= sum;
            if (last_slice) begin
              result_cout_q <= cout;
              a_in_q        <= '0;
              b_in_q        <= '0;
              carry_q       <= 1'b0;
            end else begin
              k_q     <= k_q + 1'b1;
              cnt_q   <= '0;
              a_sh    <= a_nxt;
              b_sh    <= b_nxt;
              a_in_q  <= a_nxt[4:0];
              b_in_q  <= b_nxt[4:0];
              carry_q <= cout;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
